lzc_normalizer: RTL and testbench

LZC_NORMALIZER -- requirements
Module: lzc_normalizer

---
 rtl/lzc_normalizer.sv | 171 +++++++++++++++++
 tb/tb_lzc_normalizer.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lzc_normalizer.sv
// Two-stage leading-zero count and normalize pipeline with valid/ready handshake.
// Leading-one detection uses a selectable prefix-OR structure (serial, Brent-Kung, Sklansky).
module lzc_normalizer #(
    parameter int width = 16,
    parameter int speed = 1,
    localparam int SW = $clog2(width + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [width-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [width-1:0] out_data_o,
    output logic [SW-1:0]    out_shamt_o,
    output logic             out_zero_o
);

    localparam int LEVELS = $clog2(width);

    // rev[0] is the operand MSB, so pre[j] is the OR of the top j+1 operand bits.
    logic [width-1:0] rev;
    logic [width-1:0] pre;
    logic [width-1:0] lead_oh;
    logic [SW-1:0]    lead_cnt;

    always_comb begin
        for (int j = 0; j < width; j++) begin
            rev[j] = in_data_i[width-1-j];
        end
    end

    generate
        if (speed == 0) begin : g_serial
            always_comb begin
                logic [width-1:0] p;
                p[0] = rev[0];
                for (int j = 1; j < width; j++) begin
                    p[j] = p[j-1] | rev[j];
                end
                pre = p;
            end
        end else if (speed == 1) begin : g_brent_kung
            always_comb begin
                logic [width-1:0] p;
                p = rev;
                for (int l = 0; l < LEVELS; l++) begin
                    for (int j = 0; j < width; j++) begin
                        if (((j + 1) % (1 << (l + 1))) == 0) begin
                            p[j] = p[j] | p[j - (1 << l)];
                        end
                    end
                end
                // Down-sweep fills the odd positions left between up-sweep nodes.
                for (int l = LEVELS - 2; l >= 0; l--) begin
                    for (int j = 0; j < width; j++) begin
                        if ((((j + 1) % (1 << (l + 1))) == (1 << l)) && (j + 1 > (1 << l))) begin
                            p[j] = p[j] | p[j - (1 << l)];
                        end
                    end
                end
                pre = p;
            end
        end else begin : g_sklansky
            always_comb begin
                logic [width-1:0] p;
                p = rev;
                for (int l = 0; l < LEVELS; l++) begin
                    for (int j = 0; j < width; j++) begin
                        if ((j & (1 << l)) != 0) begin
                            p[j] = p[j] | p[((j >> (l + 1)) << (l + 1)) + (1 << l) - 1];
                        end
                    end
                end
                pre = p;
            end
        end
    endgenerate

    always_comb begin
        logic [SW-1:0] enc;
        lead_oh[width-1] = rev[0];
        for (int j = 1; j < width; j++) begin
            lead_oh[width-1-j] = rev[j] & ~pre[j-1];
        end
        enc = '0;
        for (int j = 0; j < width; j++) begin
            enc = enc | (lead_oh[width-1-j] ? SW'(j) : '0);
        end
        lead_cnt = pre[width-1] ? enc : SW'(width);
    end

    logic             s1_valid_q, s1_valid_d;
    logic [width-1:0] s1_data_q,  s1_data_d;
    logic [width-1:0] s1_oh_q,    s1_oh_d;
    logic [SW-1:0]    s1_cnt_q,   s1_cnt_d;
    logic             s2_valid_q, s2_valid_d;
    logic [width-1:0] s2_data_q,  s2_data_d;
    logic [SW-1:0]    s2_cnt_q,   s2_cnt_d;
    logic             s2_zero_q,  s2_zero_d;

    logic s2_ready;
    logic s1_advance;
    logic s1_load;

    assign s2_ready   = ~s2_valid_q | out_ready_i;
    assign in_ready_o = ~s1_valid_q | s2_ready;
    assign s1_advance = s1_valid_q & s2_ready;
    assign s1_load    = in_valid_i & in_ready_o;

    always_comb begin
        // NOTE: every next-state signal starts from its held value so no path leaves it unassigned (no latch).
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_oh_d    = s1_oh_q;
        s1_cnt_d   = s1_cnt_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_cnt_d   = s2_cnt_q;
        s2_zero_d  = s2_zero_q;

        if (s1_load) begin
            s1_valid_d = 1'b1;
            s1_data_d  = in_data_i;
            s1_oh_d    = lead_oh;
            s1_cnt_d   = lead_cnt;
        end else if (s1_advance) begin
            s1_valid_d = 1'b0;
        end

        if (s1_advance) begin
            s2_valid_d = 1'b1;
            s2_data_d  = s1_data_q << s1_cnt_q;
            s2_cnt_d   = s1_cnt_q;
            s2_zero_d  = ~|s1_oh_q;
        end else if (out_ready_i) begin
            s2_valid_d = 1'b0;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: data registers are reset too, so outputs read as zero during and after reset.
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_oh_q    <= '0;
            s1_cnt_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_cnt_q   <= '0;
            s2_zero_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_oh_q    <= s1_oh_d;
            s1_cnt_q   <= s1_cnt_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_cnt_q   <= s2_cnt_d;
            s2_zero_q  <= s2_zero_d;
        end
    end

    assign out_valid_o = s2_valid_q;
    assign out_data_o  = s2_data_q;
    assign out_shamt_o = s2_cnt_q;
    assign out_zero_o  = s2_zero_q;

endmodule

// File: tb/tb_lzc_normalizer.sv
// Self-checking bench for lzc_normalizer: directed scenarios on a 16-bit Brent-Kung
// instance plus a randomized valid/ready sweep across several width/speed variants.
module tb_lzc_normalizer;

    localparam int NSW = 6;
    localparam int CFG_W [NSW] = '{8, 8, 13, 13, 16, 16};
    localparam int CFG_S [NSW] = '{0, 2, 1, 2, 0, 2};
    localparam int RING = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [4:0]  out_shamt;
    logic        out_zero;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lzc_normalizer #(.width(16), .speed(1)) u_dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_data),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .out_shamt_o(out_shamt),
        .out_zero_o (out_zero)
    );

    logic [NSW-1:0] sw_iv;
    logic [NSW-1:0] sw_or;
    logic [15:0]    sw_id [NSW];
    wire  [NSW-1:0] sw_ir;
    wire  [NSW-1:0] sw_ov;
    wire  [NSW-1:0] sw_oz;
    wire  [15:0]    sw_od [NSW];
    wire  [6:0]     sw_os [NSW];

    for (genvar g = 0; g < NSW; g++) begin : g_sw
        localparam int W   = CFG_W[g];
        localparam int SWW = $clog2(W + 1);
        logic [W-1:0]   od;
        logic [SWW-1:0] os;
        logic           ov, oz, ir;
        lzc_normalizer #(.width(W), .speed(CFG_S[g])) u_sw (
            .clk_i      (clk),
            .rst_ni     (rst_n),
            .in_valid_i (sw_iv[g]),
            .in_ready_o (ir),
            .in_data_i  (sw_id[g][W-1:0]),
            .out_valid_o(ov),
            .out_ready_i(sw_or[g]),
            .out_data_o (od),
            .out_shamt_o(os),
            .out_zero_o (oz)
        );
        assign sw_ir[g] = ir;
        assign sw_ov[g] = ov;
        assign sw_oz[g] = oz;
        assign sw_od[g] = 16'(od);
        assign sw_os[g] = 7'(os);
    end

    // Reference model: count zeros from the top bit down, then shift and truncate.
    function automatic int ref_lz(input logic [15:0] a, input int w);
        int n = 0;
        while (n < w && a[w-1-n] == 1'b0) n++;
        return n;
    endfunction

    function automatic logic [15:0] ref_mask(input int w);
        logic [31:0] m = (32'd1 << w) - 32'd1;
        return m[15:0];
    endfunction

    function automatic logic [15:0] ref_norm(input logic [15:0] a, input int w);
        logic [31:0] t = 32'(a) << ref_lz(a, w);
        return t[15:0] & ref_mask(w);
    endfunction

    task automatic test_reset;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        n_checks++;
        if ({out_data, out_shamt, out_zero} !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got data=%h shamt=%0d zero=%b want all 0", out_data, out_shamt, out_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_operand;
        logic [15:0] ops [4] = '{16'h0005, 16'h8000, 16'h0001, 16'h0000};
        logic [15:0] e_data [4] = '{16'hA000, 16'h8000, 16'h8000, 16'h0000};
        logic [4:0]  e_sh [4] = '{5'd13, 5'd0, 5'd15, 5'd16};
        logic        e_z [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_data   = ops[i];
            out_ready = 1'b1;
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL single_in_ready[%h]: got %b want 1", ops[i], in_ready);
            end
            @(negedge clk);
            in_valid = 1'b0;
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL single_early_valid[%h]: got %b want 0", ops[i], out_valid);
            end
            @(negedge clk);
            n_checks++;
            if ({out_valid, out_data, out_shamt, out_zero} !== {1'b1, e_data[i], e_sh[i], e_z[i]}) begin
                n_fail++;
                $display("FAIL single_result[%h]: got v=%b data=%h shamt=%0d zero=%b want v=1 data=%h shamt=%0d zero=%b",
                         ops[i], out_valid, out_data, out_shamt, out_zero, e_data[i], e_sh[i], e_z[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] ops [3] = '{16'h0100, 16'h0F00, 16'h7FFF};
        logic [15:0] e_data [3] = '{16'h8000, 16'hF000, 16'hFFFE};
        logic [4:0]  e_sh [3] = '{5'd7, 5'd4, 5'd1};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = (i < 3);
            in_data  = (i < 3) ? ops[i] : 16'h0;
            #1;
            if (i >= 2 && i < 5) begin
                n_checks++;
                if ({out_valid, out_data, out_shamt, out_zero} !== {1'b1, e_data[i-2], e_sh[i-2], 1'b0}) begin
                    n_fail++;
                    $display("FAIL b2b_result[%0d]: got v=%b data=%h shamt=%0d zero=%b want v=1 data=%h shamt=%0d zero=0",
                             i - 2, out_valid, out_data, out_shamt, out_zero, e_data[i-2], e_sh[i-2]);
                end
            end else begin
                n_checks++;
                if (out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_idle[%0d]: got out_valid=%b want 0", i, out_valid);
                end
            end
        end
    endtask

    task automatic test_backpressure;
        logic [15:0] ops [3] = '{16'h0003, 16'h0A00, 16'h00F0};
        logic [15:0] e_data [3] = '{16'hC000, 16'hA000, 16'hF000};
        logic [4:0]  e_sh [3] = '{5'd14, 5'd4, 5'd8};
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = ops[i];
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_accept[%0d]: got in_ready=%b want 1", i, in_ready);
            end
            @(negedge clk);
        end
        in_data = ops[2];
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_refuse[%0d]: got in_ready=%b want 0", i, in_ready);
            end
            n_checks++;
            if ({out_valid, out_data, out_shamt, out_zero} !== {1'b1, e_data[0], e_sh[0], 1'b0}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got v=%b data=%h shamt=%0d want v=1 data=%h shamt=%0d",
                         i, out_valid, out_data, out_shamt, e_data[0], e_sh[0]);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release_ready: got in_ready=%b want 1", in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                @(negedge clk);
                in_valid = 1'b0;
                #1;
            end
            n_checks++;
            if ({out_valid, out_data, out_shamt, out_zero} !== {1'b1, e_data[i], e_sh[i], 1'b0}) begin
                n_fail++;
                $display("FAIL bp_drain[%0d]: got v=%b data=%h shamt=%0d want v=1 data=%h shamt=%0d",
                         i, out_valid, out_data, out_shamt, e_data[i], e_sh[i]);
            end
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_empty: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset_midflight;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h1234;
        @(negedge clk);
        in_data = 16'h0042;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL rst_full: got out_valid=%b in_ready=%b want 1 0", out_valid, in_ready);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, in_ready, out_data} !== {2'b01, 16'h0}) begin
            n_fail++;
            $display("FAIL rst_async: got out_valid=%b in_ready=%b data=%h want 0 1 0000", out_valid, in_ready, out_data);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_stale[%0d]: got out_valid=%b want 0", i, out_valid);
            end
        end
    endtask

    task automatic test_random_sweep;
        logic [15:0] exp_mem [NSW][RING];
        int          wr_p [NSW];
        int          rd_p [NSW];
        for (int k = 0; k < NSW; k++) begin
            wr_p[k] = 0;
            rd_p[k] = 0;
        end
        for (int cyc = 0; cyc < 2500; cyc++) begin
            @(negedge clk);
            for (int k = 0; k < NSW; k++) begin
                logic [15:0] m = ref_mask(CFG_W[k]);
                bit drain = (cyc >= 2480);
                sw_iv[k] = drain ? 1'b0 : ($urandom_range(0, 3) != 0);
                sw_or[k] = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
                sw_id[k] = (16'($urandom) & m) >> $urandom_range(0, CFG_W[k]);
            end
            #1;
            for (int k = 0; k < NSW; k++) begin
                int occ = wr_p[k] - rd_p[k];
                n_checks++;
                if (sw_ir[k] !== !(occ == 2 && !sw_or[k])) begin
                    n_fail++;
                    $display("FAIL sweep_ready[w%0d s%0d] cyc %0d: got %b with %0d in flight, out_ready=%b",
                             CFG_W[k], CFG_S[k], cyc, sw_ir[k], occ, sw_or[k]);
                end
                if (sw_ov[k] && occ == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sweep_spurious[w%0d s%0d] cyc %0d: got out_valid=1 want 0 (nothing in flight)",
                             CFG_W[k], CFG_S[k], cyc);
                end else if (sw_ov[k] && sw_or[k]) begin
                    logic [15:0] a = exp_mem[k][rd_p[k] % RING];
                    logic [15:0] ed = ref_norm(a, CFG_W[k]);
                    logic [6:0]  es = 7'(ref_lz(a, CFG_W[k]));
                    n_checks++;
                    if ({sw_od[k], sw_os[k], sw_oz[k]} !== {ed, es, a == 16'h0}) begin
                        n_fail++;
                        $display("FAIL sweep_result[w%0d s%0d] in=%h: got data=%h shamt=%0d zero=%b want data=%h shamt=%0d zero=%b",
                                 CFG_W[k], CFG_S[k], a, sw_od[k], sw_os[k], sw_oz[k], ed, es, a == 16'h0);
                    end
                    rd_p[k]++;
                end
                if (sw_iv[k] && sw_ir[k]) begin
                    exp_mem[k][wr_p[k] % RING] = sw_id[k];
                    wr_p[k]++;
                end
            end
        end
        for (int k = 0; k < NSW; k++) begin
            n_checks++;
            if (wr_p[k] != rd_p[k]) begin
                n_fail++;
                $display("FAIL sweep_lost[w%0d s%0d]: got %0d results want %0d", CFG_W[k], CFG_S[k], rd_p[k], wr_p[k]);
            end
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sw_iv = '0;
        sw_or = '1;
        for (int k = 0; k < NSW; k++) sw_id[k] = '0;
        test_reset();
        test_single_operand();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_random_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
